// File: rtl/b2x_seq.sv
// b2x_seq: sequential binary -> multi-digit Excess-3 encoder.
// Iterative double-dabble, one input bit per clock, MSB first, with a
// valid/ready handshake on both sides and an overflow flag for values that
// do not fit in DIGITS decimal digits.
// Optional build macro: B2X_SAT_EN -- when defined, an overflowing value
// saturates op to all nines (4'hC per digit). When undefined, it wraps
// modulo 10^DIGITS. invalid is raised in both cases.
module b2x_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      inp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   op,
  output logic                  invalid
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [WIDTH-1:0]  r_sh;      // remaining input bits, MSB consumed first
  logic [BW-1:0]     r_bcd;     // BCD accumulator (truncated to DIGITS digits)
  logic [CW-1:0]     r_cnt;     // steps still to perform
  logic              r_ovf;     // any carry lost out of the top digit
  logic [BW-1:0]     r_op;
  logic              r_inv;
  logic              r_out_valid;

  logic [BW-1:0]     w_adj;     // accumulator after the add-3 correction
  logic [BW-1:0]     w_e3;      // accumulator converted to Excess-3
  logic [BW-1:0]     w_res;     // value presented on op at DONE entry
  logic [BW-1:0]     w_bcd_nxt;
  logic [WIDTH-1:0]  w_sh_nxt;
  logic              w_carry;
  logic              w_accept;
  logic              w_step;
  logic              w_conv_end;
  logic              w_out_hs;

  // Per-digit correction and Excess-3 bias. Digits never exceed 9, so a
  // digit >=5 becomes 8..12 and its MSB is the decimal carry after the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? (r_bcd[4*g +: 4] + 4'd3)
                                                       :  r_bcd[4*g +: 4];
    assign w_e3[4*g +: 4]  = r_bcd[4*g +: 4] + 4'd3;
  end

  // One double-dabble step: shift {adjusted bcd, shreg} left by one.
  assign w_bcd_nxt = {w_adj[BW-2:0], r_sh[WIDTH-1]};
  assign w_sh_nxt  = r_sh << 1;
  assign w_carry   = w_adj[BW-1];

`ifdef B2X_SAT_EN
  assign w_res = r_ovf ? {DIGITS{4'hC}} : w_e3;
`else
  assign w_res = w_e3;
`endif

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_step     = (r_state == S_CONV) && (r_cnt != '0);
  assign w_conv_end = (r_state == S_CONV) && (r_cnt == '0);
  assign w_out_hs   = r_out_valid && out_ready;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign op        = r_op;
  assign invalid   = r_inv;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: accept -> WIDTH steps -> one cycle to publish -> hold.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)      w_next = S_CONV;
      S_CONV:  if (r_cnt == '0)   w_next = S_DONE;
      S_DONE:  if (w_out_hs)      w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // Conversion datapath: load on accept, then one bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_sh  <= inp;
      r_bcd <= '0;
      r_cnt <= CNT_LOAD;
      r_ovf <= 1'b0;
    end else if (w_step) begin
      r_sh  <= w_sh_nxt;
      r_bcd <= w_bcd_nxt;
      r_cnt <= r_cnt - CNT_ONE;
      r_ovf <= r_ovf | w_carry;
    end
  end

  // Output registers: published on DONE entry, held until the handshake;
  // op/invalid keep their last value after out_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= '0;
      r_inv       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_conv_end) begin
      r_op        <= w_res;
      r_inv       <= r_ovf;
      r_out_valid <= 1'b1;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_b2x_seq.sv
// Testbench for b2x_seq (WIDTH=8, DIGITS=2): directed literal cases plus
// randomized traffic against a transaction-level reference model.
module tb_b2x_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 2;
  localparam int BW     = 4 * DIGITS;

  function automatic longint pow10(int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint P10 = pow10(DIGITS);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  inp = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [BW-1:0]     op;
  logic              invalid;

  int checks = 0;
  int errors = 0;

  b2x_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inp(inp), .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .invalid(invalid)
  );

  always #5 clk = ~clk;

  // Expected Excess-3 image of a value: decimal digits of v mod 10^DIGITS,
  // each +3; all nines when saturating and v does not fit.
  function automatic logic [BW-1:0] m_e3(longint v);
    logic [BW-1:0] r;
    longint x;
    x = v % P10;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10 + 3);
      x = x / 10;
    end
`ifdef B2X_SAT_EN
    if (v >= P10)
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'hC;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: idle / busy for WIDTH+1 cycles / holding a result.
  int            m_phase = 0;
  int            m_age   = 0;
  longint        m_val   = 0;
  logic [BW-1:0] m_op    = '0;
  logic          m_inv   = 1'b0;
  logic          m_ov    = 1'b0;
  logic          m_hs    = 1'b0;
  longint        m_pop   = 0;
  longint        q[$];
  int            n_acc   = 0;
  int            n_out   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_age   <= 0;
      m_op    <= '0;
      m_inv   <= 1'b0;
      m_ov    <= 1'b0;
      m_hs    <= 1'b0;
      q.delete();
      n_acc   <= n_out;
    end else begin
      m_hs <= 1'b0;
      case (m_phase)
        0: if (in_valid) begin
             m_phase <= 1;
             m_age   <= 0;
             m_val   <= longint'(inp);
             q.push_back(longint'(inp));
             n_acc   <= n_acc + 1;
           end
        1: if (m_age == WIDTH) begin
             m_phase <= 2;
             m_op    <= m_e3(m_val);
             m_inv   <= (m_val >= P10);
             m_ov    <= 1'b1;
           end else begin
             m_age <= m_age + 1;
           end
        default: if (out_ready) begin
             m_phase <= 0;
             m_ov    <= 1'b0;
             m_hs    <= 1'b1;
             m_pop   <= (q.size() > 0) ? q.pop_front() : -1;
             n_out   <= n_out + 1;
           end
      endcase
    end
  end

  // Cycle-by-cycle compare, 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("op", 32'(op), 32'(m_op));
      chk("invalid", {31'd0, invalid}, {31'd0, m_inv});
      if (m_hs) chk("order", 32'(op), 32'(m_e3(m_pop)));
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("wait_ready", 32'd0, 32'd1);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) chk("wait_out", 32'd0, 32'd1);
  endtask

  task automatic run_one(input int v, input logic [BW-1:0] e_op, input logic e_inv);
    int n;
    @(negedge clk);
    wait_ready();
    inp = WIDTH'(v); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk("latency", 32'(n), 32'(WIDTH + 1));
    chk("op_lit", 32'(op), 32'(e_op));
    chk("inv_lit", {31'd0, invalid}, {31'd0, e_inv});
    @(negedge clk);
    chk("ready_after_hs", {31'd0, in_ready}, 32'd1);
    chk("ov_after_hs", {31'd0, out_valid}, 32'd0);
    chk("op_kept", 32'(op), 32'(e_op));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int tgt;
    logic [BW-1:0] e;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_inv", {31'd0, invalid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // Basic conversions
    run_one(0,  8'h33, 1'b0);
    run_one(99, 8'hCC, 1'b0);
    run_one(42, 8'h75, 1'b0);

    // Reset in the middle of a conversion
    wait_ready();
    inp = 8'd37; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_op", 32'(op), 32'd0);
    chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_inv", {31'd0, invalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) @(negedge clk);
    chk("no_stale", {31'd0, out_valid}, 32'd0);

    // Overflow
`ifdef B2X_SAT_EN
    run_one(255, 8'hCC, 1'b1);
    run_one(100, 8'hCC, 1'b1);
`else
    run_one(255, 8'h88, 1'b1);
    run_one(100, 8'h33, 1'b1);
`endif

    // Backpressure with in_valid held high and inp changing
    @(negedge clk);
    wait_ready();
    inp = 8'd42; in_valid = 1'b1; out_ready = 1'b0;
    repeat (30) begin
      @(negedge clk);
      inp = WIDTH'($urandom);
      in_valid = 1'b1;
    end
    chk("bp_ov", {31'd0, out_valid}, 32'd1);
    chk("bp_op", 32'(op), 32'h75);
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    inp = 8'd7; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_ov", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_next_acc", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_out();
    chk("bp_next_op", 32'(op), 32'h3A);
    chk("bp_next_inv", {31'd0, invalid}, 32'd0);
    @(negedge clk);

    // Random traffic
    tgt = n_acc + 1000;
    cyc = 0;
    while (n_acc < tgt && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid  = ($urandom_range(0, 1) == 1);
      inp       = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 99));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    if (n_acc < tgt) chk("rand_budget", 32'(n_acc), 32'(tgt));
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (m_phase != 0 && cyc < 40) begin @(negedge clk); cyc++; end
    @(negedge clk);
    chk("drain_idle", 32'(m_phase), 32'd0);
    chk("one_out_per_in", 32'(n_out), 32'(n_acc));
    e = m_e3(longint'(100));
    chk("model_pin", {31'd0, e == 8'hCC || e == 8'h33}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
